// File: rtl/alu_pkg.sv
// Shared definitions for the ALU time-share arbiter: widths, one-hot opcodes, sequencer states.
package alu_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned OPW  = 37;

    // One-hot ALU instruction encodings; unused upper bits are reserved.
    localparam logic [OPW-1:0] OP_ADD   = 37'h00001;
    localparam logic [OPW-1:0] OP_SUB   = 37'h00002;
    localparam logic [OPW-1:0] OP_XOR   = 37'h00004;
    localparam logic [OPW-1:0] OP_OR    = 37'h00008;
    localparam logic [OPW-1:0] OP_AND   = 37'h00010;
    localparam logic [OPW-1:0] OP_SLL   = 37'h00020;
    localparam logic [OPW-1:0] OP_SRL   = 37'h00040;
    localparam logic [OPW-1:0] OP_SRA   = 37'h00080;
    localparam logic [OPW-1:0] OP_SLT   = 37'h00100;
    localparam logic [OPW-1:0] OP_SLTU  = 37'h00200;
    localparam logic [OPW-1:0] OP_ADDI  = 37'h00400;
    localparam logic [OPW-1:0] OP_XORI  = 37'h00800;
    localparam logic [OPW-1:0] OP_ORI   = 37'h01000;
    localparam logic [OPW-1:0] OP_ANDI  = 37'h02000;
    localparam logic [OPW-1:0] OP_SLLI  = 37'h04000;
    localparam logic [OPW-1:0] OP_SRLI  = 37'h08000;
    localparam logic [OPW-1:0] OP_SRAI  = 37'h10000;
    localparam logic [OPW-1:0] OP_SLTI  = 37'h20000;
    localparam logic [OPW-1:0] OP_SLTIU = 37'h40000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/alu_share_pick.sv
// Grant selector for the two ALU requesters.
// ALU_SHARE_RR_EN selects round-robin ties; otherwise port 0 always wins ties.
module alu_share_pick (
    input  logic clk,
    input  logic rst,
    input  logic valid0,
    input  logic valid1,
    input  logic accept,
    output logic grant
);

`ifdef ALU_SHARE_RR_EN
    // Last granted port; reset to 1 so port 0 takes the first tie.
    logic last_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= 1'b1;
        end else if (accept) begin
            last_q <= grant;
        end
    end

    always_comb begin
        grant = 1'b0;
        if (valid0 && valid1) begin
            grant = ~last_q;
        end else if (valid1) begin
            grant = 1'b1;
        end
    end
`else
    logic unused_pick;
    assign unused_pick = ^{clk, rst, accept};

    always_comb begin
        grant = valid1 && !valid0;
    end
`endif

endmodule

// File: rtl/alu_share_arbiter.sv
// Time-shares one external combinational ALU between two requesters via IDLE/EXEC/RESP sequencing.
// Tie-break policy is set by ALU_SHARE_RR_EN (round-robin when defined, port 0 priority otherwise).
module alu_share_arbiter #(
    parameter int unsigned XLEN = alu_pkg::XLEN,
    parameter int unsigned OPW  = alu_pkg::OPW
) (
    input  logic            clk,
    input  logic            rst,

    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic [OPW-1:0]  req0_instr,
    input  logic [XLEN-1:0] req0_rs1,
    input  logic [XLEN-1:0] req0_rs2,
    input  logic [XLEN-1:0] req0_imm,

    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic [OPW-1:0]  req1_instr,
    input  logic [XLEN-1:0] req1_rs1,
    input  logic [XLEN-1:0] req1_rs2,
    input  logic [XLEN-1:0] req1_imm,

    output logic            resp0_valid,
    input  logic            resp0_ready,
    output logic            resp1_valid,
    input  logic            resp1_ready,
    output logic [XLEN-1:0] resp_data,

    output logic [OPW-1:0]  alu_instr,
    output logic [XLEN-1:0] alu_rs1,
    output logic [XLEN-1:0] alu_rs2,
    output logic [XLEN-1:0] alu_imm,
    input  logic [XLEN-1:0] alu_result
);

    import alu_pkg::*;

    state_t          state_q;
    state_t          state_d;
    logic            grant;
    logic            grant_q;
    logic            accept_c;
    logic [OPW-1:0]  instr_q;
    logic [XLEN-1:0] rs1_q;
    logic [XLEN-1:0] rs2_q;
    logic [XLEN-1:0] imm_q;
    logic [XLEN-1:0] resp_data_q;

    alu_share_pick u_pick (
        .clk    (clk),
        .rst    (rst),
        .valid0 (req0_valid),
        .valid1 (req1_valid),
        .accept (accept_c),
        .grant  (grant)
    );

    // Next state plus handshake decode; ready pulses only in IDLE, valid only in RESP.
    always_comb begin
        state_d     = state_q;
        accept_c    = 1'b0;
        req0_ready  = 1'b0;
        req1_ready  = 1'b0;
        resp0_valid = 1'b0;
        resp1_valid = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req0_valid || req1_valid) begin
                    accept_c   = 1'b1;
                    req0_ready = ~grant;
                    req1_ready = grant;
                    state_d    = EXEC;
                end
            end
            EXEC: begin
                state_d = RESP;
            end
            RESP: begin
                resp0_valid = ~grant_q;
                resp1_valid = grant_q;
                if (grant_q ? resp1_ready : resp0_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, operand latch on accept, result capture at the end of EXEC.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            grant_q     <= 1'b0;
            instr_q     <= '0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            imm_q       <= '0;
            resp_data_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept_c) begin
                grant_q <= grant;
                instr_q <= grant ? req1_instr : req0_instr;
                rs1_q   <= grant ? req1_rs1   : req0_rs1;
                rs2_q   <= grant ? req1_rs2   : req0_rs2;
                imm_q   <= grant ? req1_imm   : req0_imm;
            end
            if (state_q == EXEC) begin
                resp_data_q <= alu_result;
            end
        end
    end

    assign alu_instr = instr_q;
    assign alu_rs1   = rs1_q;
    assign alu_rs2   = rs2_q;
    assign alu_imm   = imm_q;
    assign resp_data = resp_data_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: transaction-level model checked every cycle plus directed literal checks.
module tb_alu_share_arbiter;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [36:0] req0_instr, req1_instr;
    logic [31:0] req0_rs1, req0_rs2, req0_imm, req1_rs1, req1_rs2, req1_imm;
    logic        resp0_valid, resp0_ready, resp1_valid, resp1_ready;
    logic [31:0] resp_data;
    logic [36:0] alu_instr;
    logic [31:0] alu_rs1, alu_rs2, alu_imm, alu_result;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    alu_share_arbiter dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_instr(req0_instr),
        .req0_rs1(req0_rs1), .req0_rs2(req0_rs2), .req0_imm(req0_imm),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_instr(req1_instr),
        .req1_rs1(req1_rs1), .req1_rs2(req1_rs2), .req1_imm(req1_imm),
        .resp0_valid(resp0_valid), .resp0_ready(resp0_ready),
        .resp1_valid(resp1_valid), .resp1_ready(resp1_ready),
        .resp_data(resp_data),
        .alu_instr(alu_instr), .alu_rs1(alu_rs1), .alu_rs2(alu_rs2), .alu_imm(alu_imm),
        .alu_result(alu_result)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference integer ALU; anything not exactly one known opcode yields 0.
    function automatic logic [31:0] alu_model(input logic [36:0] op, input logic [31:0] a,
                                              input logic [31:0] b, input logic [31:0] i);
        logic [4:0] sb;
        logic [4:0] si;
        sb = b[4:0];
        si = i[4:0];
        case (op)
            OP_ADD:   return a + b;
            OP_SUB:   return a - b;
            OP_XOR:   return a ^ b;
            OP_OR:    return a | b;
            OP_AND:   return a & b;
            OP_SLL:   return a << sb;
            OP_SRL:   return a >> sb;
            OP_SRA:   return 32'($signed(a) >>> sb);
            OP_SLT:   return {31'b0, $signed(a) < $signed(b)};
            OP_SLTU:  return {31'b0, a < b};
            OP_ADDI:  return a + i;
            OP_XORI:  return a ^ i;
            OP_ORI:   return a | i;
            OP_ANDI:  return a & i;
            OP_SLLI:  return a << si;
            OP_SRLI:  return a >> si;
            OP_SRAI:  return 32'($signed(a) >>> si);
            OP_SLTI:  return {31'b0, $signed(a) < $signed(i)};
            OP_SLTIU: return {31'b0, a < i};
            default:  return 32'h0;
        endcase
    endfunction

    always_comb alu_result = alu_model(alu_instr, alu_rs1, alu_rs2, alu_imm);

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    // Arbitration rule: lone requester wins; ties by policy.
    function automatic logic model_pick(input logic v0, input logic v1, input logic last);
        if (v0 && v1) begin
`ifdef ALU_SHARE_RR_EN
            return !last;
`else
            return 1'b0 & last;
`endif
        end
        return v1;
    endfunction

    // Transaction model: age -1 = free, 1 = cycle after accept, 2 = response offered.
    bit          m_known = 1'b0;
    int          m_age = -1;
    logic        m_grant = 1'b0;
    logic        m_last = 1'b1;
    logic [36:0] m_instr = '0;
    logic [31:0] m_rs1 = '0, m_rs2 = '0, m_imm = '0, m_res = '0, m_data = '0;

    always @(negedge clk) begin : compare
        logic e_r0, e_r1, g;
        e_r0 = 1'b0;
        e_r1 = 1'b0;
        g = model_pick(req0_valid, req1_valid, m_last);
        if (m_known) begin
            if (m_age < 0 && (req0_valid || req1_valid)) begin
                e_r0 = !g;
                e_r1 = g;
            end
            check("cmp_req0_ready", 64'(req0_ready), 64'(e_r0));
            check("cmp_req1_ready", 64'(req1_ready), 64'(e_r1));
            check("cmp_resp0_valid", 64'(resp0_valid), 64'(m_age == 2 && !m_grant));
            check("cmp_resp1_valid", 64'(resp1_valid), 64'(m_age == 2 && m_grant));
            check("cmp_resp_data", 64'(resp_data), 64'(m_data));
            check("cmp_alu_instr", 64'(alu_instr), 64'(m_instr));
            check("cmp_alu_rs1", 64'(alu_rs1), 64'(m_rs1));
            check("cmp_alu_rs2", 64'(alu_rs2), 64'(m_rs2));
            check("cmp_alu_imm", 64'(alu_imm), 64'(m_imm));
        end
        if (rst) begin
            m_known = 1'b1; m_age = -1; m_last = 1'b1; m_grant = 1'b0;
            m_instr = '0; m_rs1 = '0; m_rs2 = '0; m_imm = '0; m_data = '0;
        end else if (m_known) begin
            if (m_age < 0) begin
                if (req0_valid || req1_valid) begin
                    m_grant = g;
                    m_last  = g;
                    m_instr = g ? req1_instr : req0_instr;
                    m_rs1   = g ? req1_rs1 : req0_rs1;
                    m_rs2   = g ? req1_rs2 : req0_rs2;
                    m_imm   = g ? req1_imm : req0_imm;
                    m_res   = alu_model(m_instr, m_rs1, m_rs2, m_imm);
                    m_age   = 1;
                end
            end else if (m_age == 1) begin
                m_data = m_res;
                m_age  = 2;
            end else if (m_grant ? resp1_ready : resp0_ready) begin
                m_age = -1;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int p, input logic v, input logic [36:0] op,
                           input logic [31:0] a, input logic [31:0] b, input logic [31:0] i);
        if (p == 0) begin
            req0_valid = v; req0_instr = op; req0_rs1 = a; req0_rs2 = b; req0_imm = i;
        end else begin
            req1_valid = v; req1_instr = op; req1_rs1 = a; req1_rs2 = b; req1_imm = i;
        end
    endtask

    // Returns at the negedge of the cycle where the ready pulse is seen.
    task automatic wait_ready(input int p, output int at);
        bit seen;
        seen = 1'b0;
        at = -1;
        for (int k = 0; k < 30 && !seen; k++) begin
            @(negedge clk);
            if ((p == 0) ? req0_ready : req1_ready) begin
                seen = 1'b1;
                at = cyc;
            end
        end
        if (!seen) check("ready_timeout", 64'(0), 64'(1));
    endtask

    task automatic wait_resp(input int p, output int at);
        bit seen;
        seen = 1'b0;
        at = -1;
        for (int k = 0; k < 30 && !seen; k++) begin
            @(negedge clk);
            if ((p == 0) ? resp0_valid : resp1_valid) begin
                seen = 1'b1;
                at = cyc;
            end
        end
        if (!seen) check("resp_timeout", 64'(0), 64'(1));
    endtask

    task automatic run_op(input int p, input logic [36:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] i, input logic [31:0] expd);
        int n, m;
        set_req(p, 1'b1, op, a, b, i);
        wait_ready(p, n);
        step();
        set_req(p, 1'b0, op, a, b, i);
        wait_resp(p, m);
        check("op_latency", 64'(m - n), 64'(2));
        check("op_data", 64'(resp_data), 64'(expd));
        check("op_other_valid", 64'((p == 0) ? resp1_valid : resp0_valid), 64'(0));
        step();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req0_ready"}, 64'(req0_ready), 64'(0));
        check({tag, "_req1_ready"}, 64'(req1_ready), 64'(0));
        check({tag, "_resp0_valid"}, 64'(resp0_valid), 64'(0));
        check({tag, "_resp1_valid"}, 64'(resp1_valid), 64'(0));
        check({tag, "_resp_data"}, 64'(resp_data), 64'(0));
        check({tag, "_alu_instr"}, 64'(alu_instr), 64'(0));
        check({tag, "_alu_rs1"}, 64'(alu_rs1), 64'(0));
        check({tag, "_alu_rs2"}, 64'(alu_rs2), 64'(0));
        check({tag, "_alu_imm"}, 64'(alu_imm), 64'(0));
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors + 1);
        $fatal(1);
    end

    initial begin : main
        int n, m, h, gcount;
        int exp_seq [4];
        logic g;
`ifdef ALU_SHARE_RR_EN
        exp_seq = '{0, 1, 0, 1};
`else
        exp_seq = '{0, 0, 0, 1};
`endif
        rst = 1'b1;
        set_req(0, 1'b0, '0, '0, '0, '0);
        set_req(1, 1'b0, '0, '0, '0, '0);
        resp0_ready = 1'b1;
        resp1_ready = 1'b1;
        step();
        step();
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("reset");
        step();

        // Single ADD on port 0
        run_op(0, OP_ADD, 32'd5, 32'd7, 32'd0, 32'd12);

        // Non-one-hot instruction passes through, result 0
        run_op(0, 37'h3, 32'd9, 32'd1, 32'd0, 32'd0);
        @(negedge clk);
        check("invalid_passthru", 64'(alu_instr), 64'(37'h3));
        step();

        // Backpressure on port 1 while port 0 waits
        resp1_ready = 1'b0;
        set_req(1, 1'b1, OP_SLLI, 32'd1, 32'd0, 32'd4);
        wait_ready(1, n);
        step();
        set_req(1, 1'b0, OP_SLLI, 32'd1, 32'd0, 32'd4);
        set_req(0, 1'b1, OP_ADD, 32'd2, 32'd3, 32'd0);
        wait_resp(1, m);
        check("bp_latency", 64'(m - n), 64'(2));
        check("bp_data", 64'(resp_data), 64'(16));
        for (int k = 0; k < 5; k++) begin
            step();
            @(negedge clk);
            check("bp_hold_valid", 64'(resp1_valid), 64'(1));
            check("bp_hold_data", 64'(resp_data), 64'(16));
            check("bp_no_ready", 64'(req0_ready), 64'(0));
        end
        step();
        resp1_ready = 1'b1;
        h = cyc;
        @(negedge clk);
        check("bp_same_cycle_ready", 64'(req0_ready), 64'(0));
        wait_ready(0, n);
        check("bp_accept_next", 64'(n - h), 64'(1));
        step();
        set_req(0, 1'b0, OP_ADD, 32'd2, 32'd3, 32'd0);
        wait_resp(0, m);
        check("bp_followup_data", 64'(resp_data), 64'(5));
        step();

        // Reset while the operation is in EXEC
        set_req(0, 1'b1, OP_ADD, 32'd1, 32'd2, 32'd0);
        wait_ready(0, n);
        step();
        set_req(0, 1'b0, OP_ADD, 32'd1, 32'd2, 32'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("midreset");
        for (int k = 0; k < 3; k++) begin
            step();
            @(negedge clk);
            check("midreset_no_resp", 64'(resp0_valid | resp1_valid), 64'(0));
        end
        step();
        run_op(1, OP_SUB, 32'd10, 32'd3, 32'd0, 32'd7);

        // Tie between both ports from a fresh reset
        rst = 1'b1;
        step();
        rst = 1'b0;
        set_req(0, 1'b1, OP_SUB, 32'd10, 32'd3, 32'd0);
        set_req(1, 1'b1, OP_XORI, 32'hF0, 32'd0, 32'h0F);
        gcount = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if ((req0_ready || req1_ready) && gcount < 4) begin
                g = req1_ready;
                check("tie_grant", 64'(g), 64'(exp_seq[gcount]));
                gcount++;
            end
            if (resp0_valid) check("tie_data0", 64'(resp_data), 64'(7));
            if (resp1_valid) check("tie_data1", 64'(resp_data), 64'(32'hFF));
            step();
`ifndef ALU_SHARE_RR_EN
            if (gcount == 3) req0_valid = 1'b0;
`endif
            if (gcount == 4) begin
                req0_valid = 1'b0;
                req1_valid = 1'b0;
            end
        end
        check("tie_count", 64'(gcount), 64'(4));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_share_arbiter.md
# alu_share_arbiter

Sequencer and arbiter that time-shares the single combinational integer ALU between two requesters, for example the execute stage and a branch/address unit.

- Accepts one operation at a time over valid/ready and drives the ALU operand and one-hot instruction inputs from internal registers.
- Captures the ALU result and returns it to the granted requester over a valid/ready response channel.
- Sits between the decode/issue logic and the ALU instance, which stays outside this block.

## Interface
Parameters:
- XLEN, 32, operand/result width
- OPW, 37, one-hot instruction vector width

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 operation accepted this cycle
- req0_instr  in  OPW  one-hot ALU operation
- req0_rs1 / req0_rs2 / req0_imm  in  XLEN  operands
- req1_valid, req1_ready, req1_instr, req1_rs1, req1_rs2, req1_imm: same as port 0, for requester 1
- resp0_valid  out  1  result available for requester 0
- resp0_ready  in  1  requester 0 consumes result
- resp1_valid  out  1  result available for requester 1
- resp1_ready  in  1  requester 1 consumes result
- resp_data  out  XLEN  result, shared by both response channels
- alu_instr  out  OPW  to ALU instruction input
- alu_rs1 / alu_rs2 / alu_imm  out  XLEN  to ALU operand inputs
- alu_result  in  XLEN  from ALU output (combinational)

## Operation
Request-side rules:
- Each requester holds valid and payload stable until it sees ready.
- reqN_ready is a combinational single-cycle pulse, asserted only in IDLE for the granted port.

FSM, 3 states:
- IDLE: if any reqN_valid, pick the grant, assert its reqN_ready, and latch instr/rs1/rs2/imm plus the grant id into operand registers. Go to EXEC. Otherwise stay.
- EXEC: alu_* outputs are driven from the operand registers. Register alu_result into resp_data. Go to RESP.
- RESP: resp{grant}_valid=1 and resp_data is held stable. When resp{grant}_ready=1, go to IDLE. The other resp_valid stays 0.

Arbitration:
- If only one port is valid, that port wins.
- If both are valid, the winner depends on the configuration (round-robin or fixed priority).

Other rules:
- alu_* outputs hold the last latched values outside EXEC; they are 0 after reset.
- Zero or non-one-hot instr is passed through unchanged; the ALU returns 0. The arbiter does not reject it.
- Requests arriving in EXEC/RESP wait; no ready is given.

## Timing
- Reset values: req0_ready=req1_ready=0, resp0_valid=resp1_valid=0, resp_data=0, all alu_*=0, state=IDLE, RR pointer favours port 0.
- Latency: accept at cycle N, result registered at edge N+1→N+2, respN_valid high from cycle N+2.
- Minimum issue interval is 3 cycles, reached when resp_ready is already high.
- Response backpressure: resp_valid stays high and resp_data stays constant until ready. There is no timeout.
- Reset mid-operation: the in-flight operation is discarded with no response; the next cycle is IDLE with reset values.
- Simultaneous resp_ready and new reqN_valid in RESP: the response completes that cycle; the new request is accepted the following cycle (IDLE).

## Configuration
Macro ALU_SHARE_RR_EN.
- Defined: round-robin arbitration. A one-bit last-grant pointer updates on each accept. On a tie, the port not granted last wins; after reset, port 0 wins the first tie.
- Undefined: fixed priority. Port 0 always wins ties; the pointer logic is absent.

## Structure
- Shared package alu_pkg holds:
  - XLEN/OPW constants
  - named one-hot opcode constants (OP_ADD=37'h1 … OP_SLTIU=37'h40000)
  - the FSM state enum {IDLE, EXEC, RESP}
- One sub-module: alu_share_pick, the combinational grant selector plus pointer register. Its inputs are the two valid bits and an accept strobe; its output is the grant id.
- The ALU is instantiated at the parent level, not inside this block.

## Test plan
- Single op: req0 ADD (37'h1) with rs1=5, rs2=7, resp0_ready=1. req0_ready pulses at N, resp0_valid at N+2, resp_data=12, resp1_valid stays 0.
- Tie with RR: both valid continuously with ops SUB (10-3) and XORI (0xF0^imm 0x0F). Grants alternate 0,1,0,1; results 7 and 0xFF go to the correct port.
- Tie without ALU_SHARE_RR_EN: both valid for 3 ops. All grants go to port 0; port 1 is served only after req0_valid drops.
- Backpressure: resp1_ready=0 for 5 cycles after SLLI (rs1=1, imm=4). resp1_valid and resp_data=16 are held; no new req ready is given during that time.
- Reset mid-op: assert rst in EXEC. The next cycle shows all outputs at reset values and no resp_valid; the following request completes normally.
- Invalid op: instr=37'h3 with rs1=9, rs2=1. The response arrives with resp_data=0 at N+2.
